// File: rtl/sid_pkg.sv
// sid_pkg: shared widths and types for the multiplier arbiter slice
package sid_pkg;
  localparam int MUL_W = 16;
  localparam int PROD_W = 32;
  localparam int ID_W = 3;
  typedef struct packed {
    logic signed [MUL_W-1:0] a;
    logic [MUL_W-1:0] b;
  } mul_req_t;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
  } tag_t;
  function automatic logic [MUL_W-1:0] prod_hi(input logic [PROD_W-1:0] p);
    return p[PROD_W-1 -: MUL_W];
  endfunction
endpackage

// File: rtl/mac_tag_pipe.sv
// mac_tag_pipe: LAT-deep tag shift register plus the slot holding the tag that just left it
module mac_tag_pipe
  import sid_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);
  // stg_q[LAT] is the exited tag, aligned with a valid mul_p
  tag_t stg_q [LAT+1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= tag_i;
      for (int i = 1; i <= LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end
  assign tag_o = stg_q[LAT];
endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin time-sharing of one registered signed x unsigned multiplier
module mac_arbiter
  import sid_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [MUL_W*NREQ-1:0]  req_a,
  input  logic [MUL_W*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [MUL_W-1:0]       rsp_data,
  output logic [MUL_W-1:0]       mul_a,
  output logic [MUL_W-1:0]       mul_b,
  input  logic [PROD_W-1:0]      mul_p
);
  localparam int PTR_W = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PTR_W-1:0] ptr_q, ptr_d, gnt_id, idx;
  logic gnt;
  logic [MUL_W-1:0] a_arr [NREQ];
  logic [MUL_W-1:0] b_arr [NREQ];
  mul_req_t op_q, op_d;
  tag_t tag_in, tag_out;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [MUL_W-1:0] rsp_data_q, rsp_data_d;
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*MUL_W +: MUL_W];
    assign b_arr[g] = req_b[g*MUL_W +: MUL_W];
  end
  // scan downward so the candidate closest to ptr is the last one written
  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt = 1'b1;
        gnt_id = idx;
      end
    end
  end
  always_comb begin
    req_ready = gnt ? NREQ'(1) << gnt_id : '0;
    ptr_d = !gnt ? ptr_q : (int'(gnt_id) == NREQ-1 ? '0 : gnt_id + 1'b1);
    op_d = gnt ? {a_arr[gnt_id], b_arr[gnt_id]} : op_q;
    tag_in = {gnt, ID_W'(gnt_id)};
    rsp_valid_d = tag_out.valid ? NREQ'(1) << tag_out.id : '0;
    rsp_data_d = tag_out.valid ? prod_hi(mul_p) : rsp_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      op_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      op_q <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  mac_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );
  assign mul_a = op_q.a;
  assign mul_b = op_q.b;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: scenario tasks plus a response scoreboard against a behavioural multiplier
module tb_mac_arbiter;
  localparam int NREQ = 4;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [16*NREQ-1:0] req_a = '0;
  logic [16*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0] rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic [31:0] p_q [LAT];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    int id;
    logic [15:0] data;
    int due;
  } exp_t;
  exp_t q[$];

  mac_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mulf(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {16'b0, b};
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    p_q[0] <= mulf(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) p_q[i] <= p_q[i-1];
  end
  assign mul_p = p_q[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    exp_t e;
    logic [31:0] p;
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge clk);
      if (rst) q.delete();
      else begin
        if (rsp_valid !== '0) begin
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got valid=%b data=%h want no response", rsp_valid, rsp_data);
          end else begin
            e = q.pop_front();
            ev = NREQ'(1) << e.id;
            if (rsp_valid !== ev || rsp_data !== e.data || cyc != e.due) begin
              n_fail++;
              $display("FAIL sb_rsp got valid=%b data=%h cyc=%0d want valid=%b data=%h cyc=%0d",
                       rsp_valid, rsp_data, cyc, ev, e.data, e.due);
            end
          end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_missing got no response at cyc=%0d want port %0d data=%h", cyc, q[0].id, q[0].data);
          void'(q.pop_front());
        end
        for (int i = 0; i < NREQ; i++)
          if (req_valid[i] && req_ready[i]) begin
            p = mulf(req_a[16*i +: 16], req_b[16*i +: 16]);
            q.push_back('{i, p[31:16], cyc + LAT + 2});
          end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== '0 || mul_a !== '0 || mul_b !== '0 || rsp_valid !== '0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b a=%h b=%h rv=%b rd=%h want all zero",
               req_ready, mul_a, mul_b, rsp_valid, rsp_data);
    end
    req_valid = 4'b1000;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 1000", req_ready);
    end
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_a[16 +: 16] = 16'h4000;
    req_b[16 +: 16] = 16'h8000;
    req_valid = 4'b0010;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if (req_ready !== 4'b0010) begin
          n_fail++;
          $display("FAIL single_ready got %b want 0010", req_ready);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (rsp_valid !== '0) begin
          n_fail++;
          $display("FAIL single_early got %b want 0000", rsp_valid);
        end
      end
      if (k == 4) begin
        n_tests++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 16'h2000) begin
          n_fail++;
          $display("FAIL single_rsp got %b/%h want 0010/2000", rsp_valid, rsp_data);
        end
      end
      step();
      if (k == 0) req_valid = '0;
    end
    drain();
  endtask

  task automatic test_signed();
    req_a[0 +: 16] = 16'hC000;
    req_b[0 +: 16] = 16'hFFFF;
    req_valid = 4'b0001;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if (req_ready !== 4'b0001) begin
          n_fail++;
          $display("FAIL signed_ready got %b want 0001", req_ready);
        end
      end
      if (k == 4) begin
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 16'hC000) begin
          n_fail++;
          $display("FAIL signed_rsp got %b/%h want 0001/c000", rsp_valid, rsp_data);
        end
      end
      step();
      if (k == 0) req_valid = '0;
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic [31:0] p;
    logic [15:0] ea [NREQ];
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'(16'h1111 * (i + 1));
      req_b[16*i +: 16] = 16'(16'h8000 + 16'h0100 * i);
      p = mulf(req_a[16*i +: 16], req_b[16*i +: 16]);
      ea[i] = p[31:16];
    end
    req_valid = 4'b1111;
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 8) begin
        n_tests++;
        if (req_ready !== NREQ'(1) << (k % NREQ)) begin
          n_fail++;
          $display("FAIL sim_grant%0d got %b want %b", k, req_ready, NREQ'(1) << (k % NREQ));
        end
      end
      if (k >= 4) begin
        n_tests++;
        if (rsp_valid !== NREQ'(1) << ((k - 4) % NREQ) || rsp_data !== ea[(k - 4) % NREQ]) begin
          n_fail++;
          $display("FAIL sim_rsp%0d got %b/%h want %b/%h", k - 4, rsp_valid, rsp_data,
                   NREQ'(1) << ((k - 4) % NREQ), ea[(k - 4) % NREQ]);
        end
      end
      step();
      if (k == 7) req_valid = '0;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    req_a[32 +: 16] = 16'd1;
    req_b[32 +: 16] = 16'hFFFF;
    req_valid = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 8) begin
        n_tests++;
        if (req_ready !== 4'b0100) begin
          n_fail++;
          $display("FAIL b2b_grant%0d got %b want 0100", k, req_ready);
        end
      end
      if (k >= 4) begin
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 16'(k - 4)) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d got %b/%h want 0100/%h", k - 4, rsp_valid, rsp_data, 16'(k - 4));
        end
      end
      step();
      if (k < 7) req_a[32 +: 16] = 16'(k + 2);
      else req_valid = '0;
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    req_a[0 +: 16] = 16'h7FFF;
    req_b[0 +: 16] = 16'hFFFF;
    req_a[16 +: 16] = 16'h1234;
    req_b[16 +: 16] = 16'h4000;
    req_valid = 4'b0011;
    step();
    step();
    req_valid = '0;
    n_tests++;
    if (mul_a !== 16'h1234) begin
      n_fail++;
      $display("FAIL mid_pre_a got %h want 1234", mul_a);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (mul_a !== '0 || mul_b !== '0 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL mid_rst got a=%h b=%h rv=%b want 0/0/0", mul_a, mul_b, rsp_valid);
    end
    step();
    rst = 1'b0;
    req_a[16 +: 16] = 16'h2000;
    req_b[16 +: 16] = 16'h0800;
    req_a[48 +: 16] = 16'h0100;
    req_b[48 +: 16] = 16'h0100;
    req_valid = 4'b1010;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_tests++;
        if (req_ready !== 4'b0010) begin
          n_fail++;
          $display("FAIL mid_grant got %b want 0010", req_ready);
        end
      end else if (k < 4) begin
        n_tests++;
        if (rsp_valid !== '0) begin
          n_fail++;
          $display("FAIL mid_stale%0d got %b want 0000", k, rsp_valid);
        end
      end else begin
        n_tests++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 16'h0100) begin
          n_fail++;
          $display("FAIL mid_rsp got %b/%h want 0010/0100", rsp_valid, rsp_data);
        end
      end
      step();
      if (k == 0) req_valid = '0;
    end
    drain();
  endtask

  task automatic test_fairness();
    int w = 0;
    logic got = 1'b0;
    req_a[0 +: 16] = 16'h0010;
    req_a[16 +: 16] = 16'h0020;
    req_a[48 +: 16] = 16'h0030;
    req_b[0 +: 16] = 16'h1000;
    req_b[16 +: 16] = 16'h2000;
    req_b[48 +: 16] = 16'h3000;
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0001 && req_ready !== 4'b1000) begin
        n_fail++;
        $display("FAIL fair_pre%0d got %b want 0001 or 1000", k, req_ready);
      end
      step();
    end
    req_valid[1] = 1'b1;
    while (!got && w < NREQ) begin
      @(negedge clk);
      w++;
      got = req_ready[1];
      step();
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL fair_join got no grant in %0d cycles want grant within %0d", w, NREQ);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready === 4'b0010 || req_ready === '0) begin
      n_fail++;
      $display("FAIL fair_nohog got %b want 0001 or 1000", req_ready);
    end
    step();
    req_valid = '0;
    drain();
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_signed();
    test_simultaneous();
    test_back_to_back();
    test_reset_midflight();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
